// File: rtl/idex_pkg.sv
// Shared definitions for the elastic pipeline registers: control bundle layout,
// FSM state type and a payload-width helper.
package idex_pkg;

    localparam int unsigned CTRL_W        = 8;
    localparam int unsigned CTRL_BRANCH   = 7;
    localparam int unsigned CTRL_MEMREAD  = 6;
    localparam int unsigned CTRL_MEMTOREG = 5;
    localparam int unsigned CTRL_MEMWRITE = 4;
    localparam int unsigned CTRL_REGWRITE = 3;
    localparam int unsigned CTRL_ALUSRC   = 2;
    localparam int unsigned CTRL_ALUOP_MSB = 1;
    localparam int unsigned CTRL_ALUOP_LSB = 0;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } elastic_state_e;

    // Packed payload: {pc, rdata1, rdata2, imm, rs1, rs2, rd, funct3, ctrl}, ctrl in the LSBs.
    function automatic int unsigned payload_w(input int unsigned xlen, input int unsigned reg_w,
                                              input int unsigned funct3_w);
        return 4 * xlen + 3 * reg_w + funct3_w + CTRL_W;
    endfunction

endpackage

// File: rtl/idex_elastic_reg_if.sv
// Decode-to-execute handshake and payload bundle for the ID/EX elastic register.
interface idex_elastic_reg_if
    import idex_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned FUNCT3_W   = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [XLEN-1:0]       in_pc;
    logic [XLEN-1:0]       in_rdata1;
    logic [XLEN-1:0]       in_rdata2;
    logic [XLEN-1:0]       in_imm;
    logic [REG_ADDR_W-1:0] in_rs1;
    logic [REG_ADDR_W-1:0] in_rs2;
    logic [REG_ADDR_W-1:0] in_rd;
    logic [FUNCT3_W-1:0]   in_funct3;
    logic [CTRL_W-1:0]     in_ctrl;

    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_pc;
    logic [XLEN-1:0]       out_rdata1;
    logic [XLEN-1:0]       out_rdata2;
    logic [XLEN-1:0]       out_imm;
    logic [REG_ADDR_W-1:0] out_rs1;
    logic [REG_ADDR_W-1:0] out_rs2;
    logic [REG_ADDR_W-1:0] out_rd;
    logic [FUNCT3_W-1:0]   out_funct3;
    logic [CTRL_W-1:0]     out_ctrl;

    // Pipeline-register side.
    modport slave (
        input  in_valid, in_pc, in_rdata1, in_rdata2, in_imm, in_rs1, in_rs2, in_rd,
               in_funct3, in_ctrl, out_ready,
        output in_ready, out_valid, out_pc, out_rdata1, out_rdata2, out_imm, out_rs1,
               out_rs2, out_rd, out_funct3, out_ctrl
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_pc, in_rdata1, in_rdata2, in_imm, in_rs1, in_rs2, in_rd,
               in_funct3, in_ctrl, out_ready,
        input  in_ready, out_valid, out_pc, out_rdata1, out_rdata2, out_imm, out_rs1,
               out_rs2, out_rd, out_funct3, out_ctrl
    );
endinterface

// File: rtl/idex_payload_reg.sv
// Load-enabled payload register with sync reset and a ctrl-only clear used on flush.
module idex_payload_reg #(
    parameter int unsigned Width = 16,
    parameter int unsigned CtrlW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             clr_ctrl_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);
    logic [Width-1:0] payload_d, payload_q;

    // Clearing ctrl wins over a load so a flushed slot can never carry side effects.
    always_comb begin
        payload_d = payload_q;
        if (clr_ctrl_i) begin
            payload_d[CtrlW-1:0] = '0;
        end else if (load_i) begin
            payload_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            payload_q <= '0;
        end else begin
            payload_q <= payload_d;
        end
    end

    assign q_o = payload_q;
endmodule

// File: rtl/idex_elastic_reg.sv
// ID/EX pipeline register with valid/ready flow control, flush and a one-entry skid
// buffer; in_ready is a flop so there is no combinational ready path back to decode.
module idex_elastic_reg
    import idex_pkg::*;
#(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned FUNCT3_W       = 4,
    parameter bit          ZERO_ON_BUBBLE = 1'b1
) (
    input logic              clk,
    input logic              reset,
    input logic              flush,
    idex_elastic_reg_if.slave bus
);
    localparam int unsigned PayW = payload_w(XLEN, REG_ADDR_W, FUNCT3_W);

    elastic_state_e state_d, state_q;
    logic           in_ready_d, in_ready_q;
    logic           accept, fire, out_valid;
    logic           load_main, load_skid, main_from_skid;
    logic [PayW-1:0] in_pay, main_d, main_q, skid_q;

    assign in_pay = {bus.in_pc, bus.in_rdata1, bus.in_rdata2, bus.in_imm, bus.in_rs1,
                     bus.in_rs2, bus.in_rd, bus.in_funct3, bus.in_ctrl};

    assign out_valid = (state_q != StEmpty);
    assign accept    = bus.in_valid & in_ready_q & ~flush;
    assign fire      = out_valid & bus.out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d   = StOne;
                        load_main = 1'b1;
                    end
                end
                StOne: begin
                    if (accept && fire) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d   = StTwo;
                        load_skid = 1'b1;
                    end else if (fire) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (fire) begin
                        state_d        = StOne;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        in_ready_d = (state_d != StTwo);
        main_d     = main_from_skid ? skid_q : in_pay;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    idex_payload_reg #(
        .Width (PayW),
        .CtrlW (CTRL_W)
    ) u_main (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load_main),
        .clr_ctrl_i (flush),
        .d_i        (main_d),
        .q_o        (main_q)
    );

    idex_payload_reg #(
        .Width (PayW),
        .CtrlW (CTRL_W)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load_skid),
        .clr_ctrl_i (flush),
        .d_i        (in_pay),
        .q_o        (skid_q)
    );

    always_comb begin
        bus.in_ready  = in_ready_q;
        bus.out_valid = out_valid;
        {bus.out_pc, bus.out_rdata1, bus.out_rdata2, bus.out_imm, bus.out_rs1, bus.out_rs2,
         bus.out_rd, bus.out_funct3} = main_q[PayW-1:CTRL_W];
        bus.out_ctrl  = (ZERO_ON_BUBBLE && !out_valid) ? '0 : main_q[CTRL_W-1:0];
    end
endmodule

// File: tb/tb_idex_elastic_reg.sv
// Self-checking bench for idex_elastic_reg: constant vector table, directed reset/stream
// sequences and randomized traffic against a 2-deep queue reference model.
module tb_idex_elastic_reg;
    import idex_pkg::*;

    localparam int unsigned XLEN = 64;
    localparam int unsigned RW   = 5;
    localparam int unsigned FW   = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] r1;
        logic [XLEN-1:0] r2;
        logic [XLEN-1:0] imm;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [RW-1:0]   rd;
        logic [FW-1:0]   f3;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    typedef struct {
        bit              rst;
        bit              fl;
        bit              iv;
        bit              ordy;
        logic [XLEN-1:0] pc;
        logic [7:0]      ctrl;
        bit              exp_valid;
        bit              exp_ready;
        logic [XLEN-1:0] exp_pc;
        logic [7:0]      exp_ctrl;
    } vec_t;

    logic clk = 1'b0;
    logic reset, flush;
    int   errors = 0;
    int   checks = 0;
    entry_t mq[$];
    bit     model_zero;

    idex_elastic_reg_if #(.XLEN(XLEN), .REG_ADDR_W(RW), .FUNCT3_W(FW)) bus ();

    idex_elastic_reg #(
        .XLEN           (XLEN),
        .REG_ADDR_W     (RW),
        .FUNCT3_W       (FW),
        .ZERO_ON_BUBBLE (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic entry_t mk_entry(input logic [XLEN-1:0] pc, input logic [7:0] ctrl);
        entry_t e;
        e.pc   = pc;
        e.r1   = {$urandom, $urandom};
        e.r2   = {$urandom, $urandom};
        e.imm  = {$urandom, $urandom};
        e.rs1  = RW'($urandom);
        e.rs2  = RW'($urandom);
        e.rd   = RW'($urandom);
        e.f3   = FW'($urandom);
        e.ctrl = ctrl;
        return e;
    endfunction

    function automatic entry_t dut_out();
        entry_t e;
        e = {bus.out_pc, bus.out_rdata1, bus.out_rdata2, bus.out_imm, bus.out_rs1, bus.out_rs2,
             bus.out_rd, bus.out_funct3, bus.out_ctrl};
        return e;
    endfunction

    // One clock: drive inputs, advance the queue model, compare DUT against it.
    task automatic step(input bit rst, input bit fl, input bit iv, input bit ordy,
                        input entry_t e);
        bit acc, fir;
        reset = rst;
        flush = fl;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        {bus.in_pc, bus.in_rdata1, bus.in_rdata2, bus.in_imm, bus.in_rs1, bus.in_rs2,
         bus.in_rd, bus.in_funct3, bus.in_ctrl} = e;
        acc = iv && (mq.size() < 2) && !fl;
        fir = (mq.size() != 0) && ordy;
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            model_zero = 1'b1;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (fir) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(e);
                model_zero = 1'b0;
            end
        end
        check("model_valid", 512'(bus.out_valid), 512'(mq.size() != 0));
        check("model_ready", 512'(bus.in_ready), 512'(mq.size() < 2));
        if (mq.size() != 0) check("model_fields", 512'(dut_out()), 512'(mq[0]));
        else if (model_zero) check("model_zero", 512'(dut_out()), 512'(0));
        else check("model_bubble_ctrl", 512'(bus.out_ctrl), 512'(0));
    endtask

    vec_t vt[11];

    initial begin
        entry_t e;
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        {bus.in_pc, bus.in_rdata1, bus.in_rdata2, bus.in_imm, bus.in_rs1, bus.in_rs2,
         bus.in_rd, bus.in_funct3, bus.in_ctrl} = '0;
        model_zero = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 512'(bus.out_valid), 512'(0));
        check("reset_ready", 512'(bus.in_ready), 512'(1));
        check("reset_fields", 512'(dut_out()), 512'(0));

        // Streaming at full rate: out_pc follows one cycle behind, no bubbles.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, mk_entry(64'h1000 + 64'(4 * i), 8'h08));
            check("stream_pc", 512'(bus.out_pc), 512'(64'h1000 + 64'(4 * i)));
            check("stream_ready", 512'(bus.in_ready), 512'(1));
        end

        // Reset held two cycles mid-stream.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, mk_entry(64'h5000, 8'hff));
            check("midrst_valid", 512'(bus.out_valid), 512'(0));
            check("midrst_ready", 512'(bus.in_ready), 512'(1));
            check("midrst_fields", 512'(dut_out()), 512'(0));
        end

        vt[0]  = '{0, 0, 1, 0, 64'h2000, 8'h48, 1, 1, 64'h2000, 8'h48};
        vt[1]  = '{0, 0, 1, 0, 64'h2004, 8'h08, 1, 0, 64'h2000, 8'h48};
        vt[2]  = '{0, 0, 1, 0, 64'h2008, 8'h11, 1, 0, 64'h2000, 8'h48};
        vt[3]  = '{0, 0, 0, 1, 64'h0,    8'h00, 1, 1, 64'h2004, 8'h08};
        vt[4]  = '{0, 0, 0, 1, 64'h0,    8'h00, 0, 1, 64'h0,    8'h00};
        vt[5]  = '{0, 0, 1, 0, 64'h3000, 8'h48, 1, 1, 64'h3000, 8'h48};
        vt[6]  = '{0, 0, 1, 0, 64'h3004, 8'hff, 1, 0, 64'h3000, 8'h48};
        vt[7]  = '{0, 1, 1, 1, 64'h3008, 8'hff, 0, 1, 64'h0,    8'h00};
        vt[8]  = '{0, 0, 0, 1, 64'h0,    8'h00, 0, 1, 64'h0,    8'h00};
        vt[9]  = '{0, 0, 1, 0, 64'h300c, 8'h01, 1, 1, 64'h300c, 8'h01};
        vt[10] = '{1, 1, 1, 1, 64'h4000, 8'hff, 0, 1, 64'h0,    8'h00};
        for (int i = 0; i < 11; i++) begin
            step(vt[i].rst, vt[i].fl, vt[i].iv, vt[i].ordy, mk_entry(vt[i].pc, vt[i].ctrl));
            check($sformatf("vec%0d_valid", i), 512'(bus.out_valid), 512'(vt[i].exp_valid));
            check($sformatf("vec%0d_ready", i), 512'(bus.in_ready), 512'(vt[i].exp_ready));
            check($sformatf("vec%0d_ctrl", i), 512'(bus.out_ctrl), 512'(vt[i].exp_ctrl));
            if (vt[i].exp_valid || vt[i].rst)
                check($sformatf("vec%0d_pc", i), 512'(bus.out_pc), 512'(vt[i].exp_pc));
        end

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            e = mk_entry({$urandom, $urandom}, 8'($urandom));
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
